// File: rtl/fb_pixel_writer.sv
// rtl/fb_pixel_writer.sv - raster pixel stream and clear-fill writer for the frame buffer
module fb_pixel_writer #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic              s_sof,
  input  logic [PIX_W-1:0]  s_data,
  output logic              s_ready,
  input  logic              clear_req,
  input  logic [PIX_W-1:0]  clear_color,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              frame_done,
  output logic              sof_err,
  output logic              busy
);

  localparam int NPIX = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    CLEAR  = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  ptr, ptr_n;
  logic [PIX_W-1:0]   color, color_n;
  logic               wr_en_n, frame_done_n, sof_err_n;
  logic [ADDR_W-1:0]  wr_addr_n;
  logic [PIX_W-1:0]   wr_data_n;
  logic               accept;

  assign s_ready = rst_n & (((state == IDLE) & ~clear_req) | (state == STREAM));
  assign accept  = s_valid & s_ready;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      color      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      color      <= color_n;
      wr_en      <= wr_en_n;
      wr_addr    <= wr_addr_n;
      wr_data    <= wr_data_n;
      frame_done <= frame_done_n;
      sof_err    <= sof_err_n;
    end
  end

  // Address/data hold their last value between writes; only wr_en qualifies them.
  always_comb begin
    state_n      = state;
    ptr_n        = ptr;
    color_n      = color;
    wr_en_n      = 1'b0;
    wr_addr_n    = wr_addr;
    wr_data_n    = wr_data;
    frame_done_n = 1'b0;
    sof_err_n    = 1'b0;

    unique case (state)
      IDLE: begin
        if (clear_req) begin
          color_n = clear_color;
          ptr_n   = '0;
          state_n = CLEAR;
        end else if (accept && s_sof) begin
          wr_en_n   = 1'b1;
          wr_addr_n = '0;
          wr_data_n = s_data;
          ptr_n     = ONE;
          state_n   = STREAM;
        end
      end

      STREAM: begin
        if (accept) begin
          wr_en_n   = 1'b1;
          wr_data_n = s_data;
          if (s_sof) begin
            // Resync wins over end-of-frame, so done and error never coincide.
            wr_addr_n = '0;
            sof_err_n = 1'b1;
            ptr_n     = ONE;
          end else begin
            wr_addr_n = ptr;
            if (ptr == LAST_ADDR) begin
              frame_done_n = 1'b1;
              ptr_n        = '0;
              state_n      = IDLE;
            end else begin
              ptr_n = ptr + ONE;
            end
          end
        end
      end

      CLEAR: begin
        wr_en_n   = 1'b1;
        wr_addr_n = ptr;
        wr_data_n = color;
        if (ptr == LAST_ADDR) begin
          frame_done_n = 1'b1;
          ptr_n        = '0;
          state_n      = IDLE;
        end else begin
          ptr_n = ptr + ONE;
        end
      end

      default: begin
        state_n = IDLE;
        ptr_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb/tb_fb_pixel_writer.sv - table-driven bench for fb_pixel_writer with NPIX=8
module tb_fb_pixel_writer;

  localparam int H_RES  = 4;
  localparam int V_RES  = 2;
  localparam int ADDR_W = 19;
  localparam int PIX_W  = 6;

  logic              clk;
  logic              rst_n;
  logic              s_valid;
  logic              s_sof;
  logic [PIX_W-1:0]  s_data;
  logic              s_ready;
  logic              clear_req;
  logic [PIX_W-1:0]  clear_color;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              frame_done;
  logic              sof_err;
  logic              busy;

  int errors = 0;
  int checks = 0;

  fb_pixel_writer #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .ADDR_W(ADDR_W),
    .PIX_W (PIX_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_sof      (s_sof),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .clear_req  (clear_req),
    .clear_color(clear_color),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .sof_err    (sof_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs for one cycle, then the outputs expected just after that cycle's edge.
  typedef struct {
    logic              rst_n;
    logic              valid;
    logic              sof;
    logic [PIX_W-1:0]  data;
    logic              clr;
    logic [PIX_W-1:0]  color;
    logic              e_ready;
    logic              e_wr;
    logic              chk_ad;
    logic [ADDR_W-1:0] e_addr;
    logic [PIX_W-1:0]  e_data;
    logic              e_done;
    logic              e_err;
    logic              e_busy;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic r, input logic v, input logic sf, input int d,
                              input logic c, input int col, input logic er, input logic ew,
                              input logic ca, input int ea, input int ed,
                              input logic edn, input logic ee, input logic eb);
    vec_t t;
    t.rst_n = r;   t.valid = v;   t.sof = sf;  t.data = PIX_W'(d);
    t.clr = c;     t.color = PIX_W'(col);
    t.e_ready = er; t.e_wr = ew;  t.chk_ad = ca;
    t.e_addr = ADDR_W'(ea);        t.e_data = PIX_W'(ed);
    t.e_done = edn; t.e_err = ee; t.e_busy = eb;
    vq.push_back(t);
  endfunction

  // Shorthand for an accepted stream beat that produces a write.
  function automatic void beat(input logic sf, input int d, input int ea,
                               input logic edn, input logic ee, input logic eb);
    add(1, 1, sf, d, 0, 0, 1, 1, 1, ea, d, edn, ee, eb);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=0x%0h expected=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst_n       = v.rst_n;
    s_valid     = v.valid;
    s_sof       = v.sof;
    s_data      = v.data;
    clear_req   = v.clr;
    clear_color = v.color;
    #1;
    chk("s_ready", idx, 32'(s_ready), 32'(v.e_ready));
    @(posedge clk);
    #1;
    chk("wr_en", idx, 32'(wr_en), 32'(v.e_wr));
    if (v.chk_ad) begin
      chk("wr_addr", idx, 32'(wr_addr), 32'(v.e_addr));
      chk("wr_data", idx, 32'(wr_data), 32'(v.e_data));
    end
    chk("frame_done", idx, 32'(frame_done), 32'(v.e_done));
    chk("sof_err", idx, 32'(sof_err), 32'(v.e_err));
    chk("busy", idx, 32'(busy), 32'(v.e_busy));
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b1; s_sof = 1'b1; s_data = '0;
    clear_req = 1'b0; clear_color = '0;

    // Reset with a pending beat, then release.
    add(0, 1, 1, 9, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 9, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    // Back-to-back frame, data 1..8.
    for (int i = 0; i < 8; i++)
      beat(i == 0, i + 1, i, i == 7, 0, i != 7);

    // Two stray non-sof beats in IDLE, then a gapped frame.
    add(1, 1, 0, 6'h2A, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 6'h2B, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      beat(i == 0, 6'h10 + i, i, i == 7, 0, i != 7);
      if (i != 7)
        add(1, 0, 0, 0, 0, 0, 1, 0, 1, i, 6'h10 + i, 0, 0, 1);
    end
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    // Resync on the fourth beat, then seven more beats to frame end.
    beat(1, 6'h20, 0, 0, 0, 1);
    beat(0, 6'h21, 1, 0, 0, 1);
    beat(0, 6'h22, 2, 0, 0, 1);
    beat(1, 6'h23, 0, 0, 1, 1);
    for (int i = 1; i < 8; i++)
      beat(0, 6'h23 + i, i, i == 7, 0, i != 7);

    // Clear fill: a pending sof beat must be refused, colour changes ignored.
    add(1, 1, 1, 6'h01, 1, 6'h3F, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++)
      add(1, 1, 1, 6'h01, 0, 6'h05 + i, 0, 1, 1, i, 6'h3F, i == 7, 0, i != 7);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    foreach (vq[i]) apply(vq[i], i);

    // Reset after the fifth pixel abandons the frame; a new sof restarts at 0.
    vq.delete();
    for (int i = 0; i < 5; i++)
      beat(i == 0, 6'h30 + i, i, 0, 0, 1);
    add(0, 1, 0, 6'h35, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    beat(1, 6'h11, 0, 0, 0, 1);
    beat(0, 6'h12, 1, 0, 0, 1);
    foreach (vq[i]) apply(vq[i], 1000 + i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
Write-side controller for the 640x480, 6-bit-per-pixel frame buffer. It accepts a raster-order pixel stream with a valid/ready handshake and start-of-frame marker, and generates sequential write addresses and data for the buffer's write port. It also provides a hardware clear-screen fill. It sits between the pixel source (image loader or renderer) and the frame buffer; the VGA scan-out path reads the buffer independently.

Parameters:
H_RES, 640, active pixels per line
V_RES, 480, active lines per frame
ADDR_W, 19, write address width; must satisfy 2**ADDR_W >= H_RES*V_RES
PIX_W, 6, pixel width; bit order [5:4]=B, [3:2]=G, [1:0]=R

Ports:
clk  in  1  pixel/system clock
rst_n  in  1  synchronous active-low reset
s_valid  in  1  input pixel beat valid
s_sof  in  1  beat is the first pixel of a frame (address 0)
s_data  in  PIX_W  input pixel
s_ready  out  1  writer accepts a beat this cycle
clear_req  in  1  level request to fill the buffer with clear_color
clear_color  in  PIX_W  fill colour, captured on entry to CLEAR
wr_en  out  1  frame buffer write strobe
wr_addr  out  ADDR_W  frame buffer write address
wr_data  out  PIX_W  frame buffer write data
frame_done  out  1  one-cycle pulse coincident with the last-pixel write
sof_err  out  1  one-cycle pulse: s_sof seen mid-frame
busy  out  1  high in STREAM or CLEAR

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n; it is sampled only on the rising edge of clk.
- Terminology: NPIX = H_RES*V_RES. A beat is accepted when s_valid & s_ready.
- States and outputs: states are IDLE, STREAM and CLEAR. Internal pointer ptr is ADDR_W bits wide.
- Reset state: state=IDLE, ptr=0.
- Registered outputs: wr_en, wr_addr, wr_data, frame_done and sof_err are registered. All are 0 after reset.
- busy: decoded from state; 0 after reset.
- s_ready: combinational. s_ready = rst_n & ((state==IDLE & !clear_req) | state==STREAM). It is therefore 0 while reset is asserted.
- Write latency: a write is issued exactly 1 cycle after its beat is accepted, or after its CLEAR step. wr_en is high for exactly 1 cycle per pixel.
- IDLE:
  - If clear_req=1: capture clear_color, set ptr=0, go to CLEAR. clear_req has priority; s_ready=0 that cycle.
  - Else, on an accepted beat with s_sof=1: write s_data to address 0, set ptr=1, go to STREAM.
  - Accepted beats with s_sof=0 are discarded: no write, no flag.
- STREAM:
  - Accepted beat with s_sof=0: write s_data to ptr, then ptr=ptr+1.
  - Accepted beat with s_sof=1: resync. Pulse sof_err together with the write, write to address 0, set ptr=1, stay in STREAM.
  - Last pixel: when the accepted beat is at ptr==NPIX-1, the write carries frame_done=1. ptr returns to 0 and state returns to IDLE.
  - clear_req is ignored in STREAM. It is honoured on the first IDLE cycle in which it is still asserted.
  - s_valid=0 cycles stall: no write, ptr holds.
- CLEAR:
  - One write per cycle of the captured colour to addresses 0..NPIX-1 (NPIX cycles). s_ready=0 throughout.
  - The write to NPIX-1 carries frame_done=1; state returns to IDLE.
  - clear_color changes during CLEAR have no effect.
- Address width: wr_addr never exceeds NPIX-1, and ptr never wraps past NPIX-1. The comparison is done at ADDR_W width.
- Reset mid-operation: on the cycle rst_n is sampled low, the next state is IDLE, ptr=0, and all registered outputs are 0. A partially written frame is abandoned with no frame_done.
- Simultaneous events:
  - s_sof on the beat at ptr==NPIX-1 in STREAM: treated as resync. Address 0 is written, sof_err=1, frame_done=0, stay in STREAM.
  - frame_done and sof_err are never both 1.

Test Plan:
(Run with H_RES=4, V_RES=2, so NPIX=8, unless stated.)
1. Reset with s_valid=1 -> s_ready=0 during reset. After release: wr_en, frame_done, sof_err and busy are 0, and s_ready=1.
2. Eight beats, first with s_sof=1, data 0x01..0x08, issued back-to-back -> wr_addr 0..7 with wr_data 0x01..0x08 on consecutive cycles, each 1 cycle after acceptance. frame_done=1 only with addr 7. busy drops after that write.
3. Same frame with s_valid toggling every other cycle, plus two leading s_sof=0 beats in IDLE -> leading beats are not written. Addresses remain contiguous 0..7; no write on gap cycles.
4. s_sof=1 on the 4th beat of a frame -> sof_err pulses with the write to addr 0. The following beats go to 1, 2, ...; frame_done arrives after 7 more beats.
5. clear_req=1, clear_color=0x3F in IDLE, with clear_color changed mid-fill -> 8 consecutive writes of 0x3F to addresses 0..7. s_ready=0 throughout; frame_done with addr 7. Then back to IDLE.
6. rst_n low for 1 cycle after the 5th pixel of a frame -> no frame_done. A new s_sof beat then writes to addr 0.
